// File: rtl/oufbuf_frame_sched_if.sv
// oufbuf_frame_sched_if: signal bundle between the frame scheduler, converter, DPSRAM and LCD timing
interface oufbuf_frame_sched_if #(parameter int ADDR_W = 17);
  logic              iStart;
  logic              oCnnStart;
  logic              iPixValid;
  logic              oWrEn;
  logic [ADDR_W:0]   oWrAddr;
  logic              iLcdFrameStart;
  logic              iLcdRdEn;
  logic [ADDR_W:0]   oRdAddr;
  logic              oFrameDone;
  logic              oBusy;
  logic              oOverrun;
  modport slave (
    input  iStart, iPixValid, iLcdFrameStart, iLcdRdEn,
    output oCnnStart, oWrEn, oWrAddr, oRdAddr, oFrameDone, oBusy, oOverrun
  );
  modport master (
    output iStart, iPixValid, iLcdFrameStart, iLcdRdEn,
    input  oCnnStart, oWrEn, oWrAddr, oRdAddr, oFrameDone, oBusy, oOverrun
  );
endinterface

// File: rtl/oufbuf_frame_sched.sv
// oufbuf_frame_sched: kicks the CNN, steers writes into the back bank and swaps banks at LCD frame starts
module oufbuf_frame_sched #(
  parameter int WIDTH    = 480,
  parameter int HEIGHT   = 272,
  parameter int ADDR_W   = 17,
  parameter bit AUTO_RUN = 1'b0
) (
  input logic                  iClk,
  input logic                  iRst,
  oufbuf_frame_sched_if.slave  bus
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  typedef enum logic [1:0] {S_IDLE, S_KICK, S_WRITE, S_WAIT} state_t;
  state_t            r_state, w_next;
  logic              r_wr_bank, r_rd_bank, r_pend;
  logic              r_cnn_start, r_frame_done, r_busy, r_overrun;
  logic [ADDR_W-1:0] r_wr_cnt, r_rd_cnt;
  logic              w_wr, w_last, w_swap;
  assign w_wr   = bus.iPixValid && r_state == S_WRITE;
  assign w_last = w_wr && r_wr_cnt == LAST;
  // pend is the registered flag, so a frame finishing on the same cycle as a frame start waits one more LCD frame
  assign w_swap = bus.iLcdFrameStart && r_pend;
  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.iStart ? S_KICK : S_IDLE;
      S_KICK:  w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_WAIT : S_WRITE;
      default: w_next = w_swap ? (AUTO_RUN ? S_KICK : S_IDLE) : S_WAIT;
    endcase
  end
  // state register
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  // registered status pulses, decoded from the upcoming state so they line up with it
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_cnn_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cnn_start  <= w_next == S_KICK;
      r_busy       <= w_next != S_IDLE;
      r_frame_done <= w_last;
      r_overrun    <= r_overrun | (bus.iPixValid && r_state != S_WRITE);
    end
  // write counter, bank ownership and pending-frame flag
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b1;
      r_rd_bank <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_wr_cnt <= (r_state == S_KICK || w_last) ? '0 : w_wr ? r_wr_cnt + ONE : r_wr_cnt;
      r_pend   <= w_last | (r_pend & ~w_swap);
      if (w_swap) begin
        r_wr_bank <= r_rd_bank;
        r_rd_bank <= r_wr_bank;
      end
    end
  // read counter: frame start rewinds, data-enable advances with wrap
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) r_rd_cnt <= '0;
    else      r_rd_cnt <= bus.iLcdFrameStart ? '0 : !bus.iLcdRdEn ? r_rd_cnt : r_rd_cnt == LAST ? '0 : r_rd_cnt + ONE;
  assign bus.oWrEn      = w_wr;
  assign bus.oWrAddr    = {r_wr_bank, r_wr_cnt};
  assign bus.oRdAddr    = {r_rd_bank, r_rd_cnt};
  assign bus.oCnnStart  = r_cnn_start;
  assign bus.oFrameDone = r_frame_done;
  assign bus.oBusy      = r_busy;
  assign bus.oOverrun   = r_overrun;
endmodule

// File: tb/tb_oufbuf_frame_sched.sv
// tb_oufbuf_frame_sched: scoreboard bench driving a manual-start and an auto-run scheduler with shared stimulus
module tb_oufbuf_frame_sched;
  localparam int W = 4, H = 2, AW = 3, DEPTH = W * H;
  localparam int IDLE = 0, KICK = 1, WRITE = 2, WAIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  oufbuf_frame_sched_if #(.ADDR_W(AW)) b0 ();
  oufbuf_frame_sched_if #(.ADDR_W(AW)) b1 ();
  oufbuf_frame_sched #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .AUTO_RUN(1'b0)) u0 (.iClk(clk), .iRst(rst), .bus(b0));
  oufbuf_frame_sched #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .AUTO_RUN(1'b1)) u1 (.iClk(clk), .iRst(rst), .bus(b1));
  typedef struct {
    int phase;
    int wbank, rbank, wcnt, rcnt;
    bit pend, done, kick, busy, ovr;
  } mdl_t;
  typedef struct {
    bit          wr_en, cnn, done, busy, ovr;
    logic [AW:0] wa, ra;
  } exp_t;
  mdl_t m [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int n_tests = 0;
  int n_fail  = 0;
  function automatic mdl_t mreset();
    mdl_t r;
    r.phase = IDLE; r.wbank = 1; r.rbank = 0; r.wcnt = 0; r.rcnt = 0;
    r.pend = 0; r.done = 0; r.kick = 0; r.busy = 0; r.ovr = 0;
    return r;
  endfunction
  // one clock of the behaviour: what the frame pipeline looks like after this edge
  function automatic mdl_t step(mdl_t s, bit st, bit pix, bit fs, bit rd, bit auto_run);
    mdl_t n;
    bit wr, last, swap;
    n    = s;
    wr   = pix && s.phase == WRITE;
    last = wr && s.wcnt == DEPTH - 1;
    swap = fs && s.pend;
    if (pix && !wr) n.ovr = 1;
    n.done = last;
    if (wr) n.wcnt = (s.wcnt + 1) % DEPTH;
    if (s.phase == KICK) n.wcnt = 0;
    if (last) n.pend = 1;
    if (swap) begin
      n.wbank = s.rbank;
      n.rbank = s.wbank;
      n.pend  = 0;
    end
    if (fs) n.rcnt = 0;
    else if (rd) n.rcnt = (s.rcnt + 1) % DEPTH;
    if (s.phase == IDLE && st) n.phase = KICK;
    else if (s.phase == KICK) n.phase = WRITE;
    else if (last) n.phase = WAIT;
    else if (s.phase == WAIT && swap) n.phase = auto_run ? KICK : IDLE;
    n.kick = n.phase == KICK;
    n.busy = n.phase != IDLE;
    return n;
  endfunction
  task automatic cyc(bit st, bit pix, bit fs, bit rd, bit rs);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs;
    b0.iStart = st; b0.iPixValid = pix; b0.iLcdFrameStart = fs; b0.iLcdRdEn = rd;
    b1.iStart = st; b1.iPixValid = pix; b1.iLcdFrameStart = fs; b1.iLcdRdEn = rd;
    for (int k = 0; k < 2; k++) begin
      if (rs) m[k] = mreset();
      e.wr_en = !rs && pix && m[k].phase == WRITE;
      e.wa    = (AW+1)'(m[k].wbank * DEPTH + m[k].wcnt);
      e.ra    = (AW+1)'(m[k].rbank * DEPTH + m[k].rcnt);
      e.cnn   = m[k].kick;
      e.done  = m[k].done;
      e.busy  = m[k].busy;
      e.ovr   = m[k].ovr;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (!rs) m[k] = step(m[k], st, pix, fs, rd, k == 1);
    end
  endtask
  task automatic cmp(string nm, int k, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask
  task automatic check(int k, exp_t e);
    exp_t a;
    a.wr_en = k ? b1.oWrEn      : b0.oWrEn;
    a.wa    = k ? b1.oWrAddr    : b0.oWrAddr;
    a.ra    = k ? b1.oRdAddr    : b0.oRdAddr;
    a.cnn   = k ? b1.oCnnStart  : b0.oCnnStart;
    a.done  = k ? b1.oFrameDone : b0.oFrameDone;
    a.busy  = k ? b1.oBusy      : b0.oBusy;
    a.ovr   = k ? b1.oOverrun   : b0.oOverrun;
    cmp("wr_en",   k, int'(a.wr_en), int'(e.wr_en));
    cmp("wr_addr", k, int'(a.wa),    int'(e.wa));
    cmp("rd_addr", k, int'(a.ra),    int'(e.ra));
    cmp("cnn",     k, int'(a.cnn),   int'(e.cnn));
    cmp("done",    k, int'(a.done),  int'(e.done));
    cmp("busy",    k, int'(a.busy),  int'(e.busy));
    cmp("overrun", k, int'(a.ovr),   int'(e.ovr));
  endtask
  // monitor: compares whatever the stimulus has queued for this cycle
  initial forever begin
    @(negedge clk);
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end
  initial begin
    b0.iStart = 0; b0.iPixValid = 0; b0.iLcdFrameStart = 0; b0.iLcdRdEn = 0;
    b1.iStart = 0; b1.iPixValid = 0; b1.iLcdFrameStart = 0; b1.iLcdRdEn = 0;
    m[0] = mreset();
    m[1] = mreset();
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(i == 3, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (DEPTH + 1) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(5) == 0, $urandom_range(2) != 0, $urandom_range(9) == 0,
          $urandom_range(1) == 1, $urandom_range(399) == 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
